// File: rtl/down_counter_underflow.sv
// Loadable down-counter with sticky and pulsed underflow reporting.
// Optional auto-reload turns it into a periodic tick/timeout source.
//
// state | meaning
// IDLE  | after reset, waiting for the first load; enable ignored
// RUN   | counting down on enable
// HALT  | underflowed with auto_reload=0; holds at zero until reloaded
module down_counter_underflow #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic             clear_underflow,
    output logic [WIDTH-1:0] counter_out,
    output logic             underflow_out,
    output logic             underflow_pulse,
    output logic             zero_out,
    output logic             busy_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            counter_out     <= ZERO;
            reload_reg      <= ZERO;
            underflow_out   <= 1'b0;
            underflow_pulse <= 1'b0;
            zero_out        <= 1'b1;
            busy_out        <= 1'b0;
        end else begin
            underflow_pulse <= 1'b0;
            if (clear_underflow)
                underflow_out <= 1'b0;

            if (load) begin
                counter_out <= load_value;
                reload_reg  <= load_value;
                state       <= RUN;
                busy_out    <= 1'b1;
                zero_out    <= (load_value == ZERO);
            end else if (state == RUN && enable) begin
                if (counter_out != ZERO) begin
                    counter_out <= counter_out - ONE;
                    zero_out    <= (counter_out == ONE);
                end else begin
                    // Underflow event; the set below overrides a same-edge clear.
                    underflow_pulse <= 1'b1;
                    underflow_out   <= 1'b1;
                    if (auto_reload) begin
                        counter_out <= reload_reg;
                        zero_out    <= (reload_reg == ZERO);
                    end else begin
                        state    <= HALT;
                        busy_out <= 1'b0;
                        zero_out <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/down_counter_underflow.md
# down_counter_underflow

Loadable WIDTH-bit down-counter with underflow detection, the count-down counterpart of the team's up-counter/overflow block. A host loads a start value; the block decrements on each enabled clock and flags underflow when a decrement is requested at zero. Underflow is reported as a sticky flag and as a one-cycle pulse. Optional auto-reload lets it serve as a periodic tick/timeout generator in the control path.

## Interface

**Parameters**
- WIDTH, 4, counter width in bits (≥2).

**Ports**
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  start value, captured when load=1.
- enable  input  1  decrement request.
- auto_reload  input  1  selects the action taken at an underflow: 1 = reload from the reload register, 0 = halt.
- clear_underflow  input  1  synchronous clear of the sticky flag.
- counter_out  output  WIDTH  current count.
- underflow_out  output  1  sticky underflow flag.
- underflow_pulse  output  1  one-cycle underflow strobe.
- zero_out  output  1  high when counter_out == 0.
- busy_out  output  1  high while the FSM is in RUN.

## Operation

**Storage**
- counter register, WIDTH bits.
- reload register, WIDTH bits, holds the last load_value.
- 2-bit FSM with states IDLE, RUN, HALT.

**Reset** (asynchronous, acts immediately, independent of clk)
- counter_out=0, reload register=0, underflow_out=0, underflow_pulse=0, zero_out=1, busy_out=0, state=IDLE.

**Priority per edge:** reset > load > decrement.

**load=1 (any state)**
- counter ← load_value; reload register ← load_value; state ← RUN.
- enable is ignored on that edge: no decrement, no underflow.
- load_value=0 is legal: the FSM enters RUN, and the next enabled edge underflows.

**IDLE / HALT**
- enable is ignored and the counter holds.
- Only load leaves these states.

**RUN, enable=1, counter≠0**
- counter ← counter−1.

**RUN, enable=1, counter==0 (underflow event)**
- underflow_pulse ← 1 for exactly one cycle.
- underflow_out ← 1.
- If auto_reload=1: counter ← reload register; stay in RUN.
- If auto_reload=0: counter stays 0; state ← HALT.
- auto_reload is sampled on the event edge only.

**RUN, enable=0**
- Counter holds.

**Arithmetic**
- Unsigned modulo-2^WIDTH.
- The counter never wraps to all-ones: the zero case is always handled as an underflow event.

**underflow_out**
- Cleared by clear_underflow=1.
- If clear_underflow and an underflow event occur on the same edge, set wins and the flag stays 1.

**Derived outputs**
- zero_out and busy_out are registered and reflect the post-edge counter and state.
- underflow_pulse deasserts on the next edge unless a new event occurs.

## Timing

- All outputs are registered; latency from a sampled input to a visible output is one rising edge.
- Back-to-back underflow pulses are possible only with auto_reload=1 and a reload value of 0 (pulse every enabled cycle).
- Reset asserted mid-count takes effect without a clock edge. The pending pulse is cancelled, and the FSM stays in IDLE after release until a load.
- Inputs must meet setup/hold to clk.
- Reset deassertion is synchronized externally.

## Test plan

All scenarios use WIDTH=4.

1. **Reset and IDLE:** assert reset between edges → all outputs take their reset values before the next edge. Release, hold enable=1 with no load for 5 edges → counter_out stays 0, underflow_out=0, busy_out=0.
2. **Halt on underflow:** load_value=3, load, then auto_reload=0 with enable held → counter_out 3,2,1,0 on successive edges, zero_out=1 at 0. The next edge gives underflow_pulse=1 for one cycle, underflow_out=1, busy_out=0, counter_out=0. Further enables cause no change.
3. **Auto-reload:** load_value=2, auto_reload=1, enable held → counter sequence 2,1,0,2,1,0,2. underflow_pulse=1 exactly on each 0→2 edge; busy_out stays 1.
4. **Load vs. enable:** in HALT with counter=0, drive load=1, load_value=5 and enable=1 on the same edge → counter_out=5, busy_out=1, no pulse.
5. **Clear vs. set:** with underflow_out=1, assert clear_underflow on the same edge as a new underflow event → underflow_out stays 1. clear_underflow alone on the next edge → underflow_out=0.
6. **Reset mid-count:** load 9, decrement to 7, assert reset asynchronously → counter_out=0, zero_out=1, busy_out=0 immediately. After release, enable alone does nothing; load 4 resumes counting 4,3,….
